dmem_access_ctrl: RTL and testbench

//  MEM-stage controller between the pipeline and the word-organised data memory.

---
 rtl/dmem_ctrl_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 36 +++
 rtl/dmem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: RV32 load/store
// func3 codes, controller states and request legality check.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_e;

  // True for conflicting strobes, an unknown func3 or a misaligned half/word.
  function automatic logic req_bad(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = rd & wr;
    if (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    if (wr && (f3 > F3_W)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends a load lane from a memory word, and
// merges store data into a word for sub-word read-modify-write.
module lsu_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rword_i[{off_i, 3'b000} +: 8];
  assign half_lane = rword_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    case (func3_i)
      F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_o = {24'h000000, byte_lane};
      F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_o = {16'h0000, half_lane};
      default: load_o = rword_i;
    endcase

    merge_o = rword_i;
    if (func3_i[1:0] == 2'b00)
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (func3_i[1:0] == 2'b01)
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: stalls the pipeline while it runs the data memory's
// strobe/busywait handshake, with read-modify-write for SB/SH and a transfer timeout.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_func3,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_busywait,
  output logic              cpu_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_busywait
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              mrd_q;
  logic              mwr_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       mwdata_q;

  logic              xfer_done_d;
  logic              tmo_d;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              unused_addr;

  assign unused_addr = ^cpu_addr[31:ADDR_W+2];

  lsu_lane_align u_align (
    .func3_i (f3_q),
    .off_i   (off_q),
    .rword_i (mem_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_val),
    .merge_o (merged)
  );

  // Busy is raised combinationally by the memory, so the first cycle in a state is ignored.
  assign xfer_done_d = (cnt_q != '0) && !mem_busywait;
  assign tmo_d       = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign cpu_busywait = (state_q == S_IDLE && (cpu_read || cpu_write)) ||
                        state_q == S_RD || state_q == S_WR ||
                        state_q == S_RMW_RD || state_q == S_RMW_WR;

  assign cpu_rdata   = rdata_q;
  assign cpu_error   = err_q;
  assign mem_read    = mrd_q;
  assign mem_write   = mwr_q;
  assign mem_address = maddr_q;
  assign mem_wdata   = mwdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_read || cpu_write) begin
            off_q   <= cpu_addr[1:0];
            f3_q    <= cpu_func3;
            wdata_q <= cpu_wdata[15:0];
            maddr_q <= cpu_addr[ADDR_W+1:2];
            cnt_q   <= '0;
            if (req_bad(cpu_read, cpu_write, cpu_func3, cpu_addr[1:0])) begin
              state_q <= S_DONE;
              err_q   <= 1'b1;
            end else if (cpu_read) begin
              state_q <= S_RD;
              mrd_q   <= 1'b1;
            end else if (cpu_func3 == F3_W) begin
              state_q  <= S_WR;
              mwr_q    <= 1'b1;
              mwdata_q <= cpu_wdata;
            end else begin
              state_q <= S_RMW_RD;
              mrd_q   <= 1'b1;
            end
          end
        end
        S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
          if (xfer_done_d) begin
            cnt_q <= '0;
            case (state_q)
              S_RD: begin
                rdata_q <= load_val;
                mrd_q   <= 1'b0;
                state_q <= S_DONE;
              end
              S_RMW_RD: begin
                mrd_q    <= 1'b0;
                mwr_q    <= 1'b1;
                mwdata_q <= merged;
                state_q  <= S_RMW_WR;
              end
              default: begin
                mwr_q   <= 1'b0;
                state_q <= S_DONE;
              end
            endcase
          end else if (tmo_d) begin
            cnt_q   <= '0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench for dmem_access_ctrl: a latency-programmable word memory plus a
// reference model of load/store results, stall lengths, errors and memory contents.
module tb_dmem_access_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              reset;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic [2:0]        cpu_func3;
  logic [31:0]       cpu_rdata;
  logic              cpu_busywait, cpu_error;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_busywait;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_func3    (cpu_func3),
    .cpu_rdata    (cpu_rdata),
    .cpu_busywait (cpu_busywait),
    .cpu_error    (cpu_error),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_busywait (mem_busywait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: busy for lat_cfg cycles after a strobe rises, then completes in one cycle.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          bcnt;
  int          lat_cfg;
  logic        stuck;
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  assign mem_busywait = (mem_read || mem_write) && (stuck || bcnt < lat_cfg);
  assign mem_rdata    = mem[mem_address];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (!(mem_read || mem_write)) bcnt <= 0;
    else if (!mem_busywait) begin
      if (mem_write) mem[mem_address] <= mem_wdata;
      bcnt <= 0;
    end else bcnt <= bcnt + 1;
  end

  int          n_cmp, n_bad;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input int off);
    logic [31:0] v;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd5: v = v % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                          input int off, input logic [31:0] d);
    logic [31:0] mask;
    if (f3 == 3'd2) return d;
    mask = ((f3 == 3'd0) ? 32'h000000FF : 32'h0000FFFF) << (8 * off);
    return (w & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input int lat, input logic stk);
    logic [7:0]  word;
    int          off, sz, stall, rdph, wrph, addr_bad, exp_stall, exp_rdph, exp_wrph;
    logic        bad, exp_err, prev_rd, prev_wr, ok;
    logic [31:0] wseen, new_word;
    word = addr[9:2];
    off  = int'(addr[1:0]);
    sz   = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
    bad  = (rd && wr) || (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
           (wr && f3 > 3'd2) || (int'(addr) % sz != 0);
    exp_err   = bad || stk;
    exp_stall = bad ? 1 : stk ? 1 + TIMEOUT : (rd || f3 == 3'd2) ? lat + 2 : 2 * lat + 3;
    exp_rdph  = (!bad && (rd || f3 != 3'd2)) ? 1 : 0;
    exp_wrph  = (!bad && !stk && wr) ? 1 : 0;
    new_word  = m_store(ref_mem[word], f3, off, wd);
    if (!bad && !stk) begin
      if (rd) exp_rdata = m_load(ref_mem[word], f3, off);
      else    ref_mem[word] = new_word;
    end

    lat_cfg = lat; stuck = stk;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_func3 = f3; cpu_wdata = wd;
    stall = 0; rdph = 0; wrph = 0; addr_bad = 0; prev_rd = 1'b0; prev_wr = 1'b0;
    ok = 1'b0; wseen = 32'h0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!cpu_busywait) begin ok = 1'b1; break; end
      stall++;
      if (mem_read && !prev_rd) rdph++;
      if (mem_write && !prev_wr) begin wrph++; wseen = mem_wdata; end
      if ((mem_read || mem_write) && mem_address != word) addr_bad++;
      prev_rd = mem_read; prev_wr = mem_write;
    end
    chk("done_reached", 32'(ok), 32'd1);
    chk("stall_cycles", stall, exp_stall);
    chk("cpu_error", 32'(cpu_error), 32'(exp_err));
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("read_phases", rdph, exp_rdph);
    chk("write_phases", wrph, exp_wrph);
    chk("strobe_in_done", {30'h0, mem_read, mem_write}, 32'h0);
    chk("mem_address", addr_bad, 32'd0);
    chk("mem_word", mem[word], ref_mem[word]);
    if (exp_wrph == 1) chk("write_data", wseen, new_word);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0; stuck = 1'b0;
    chk("error_cleared", 32'(cpu_error), 32'h0);
  endtask

  initial begin
    int          seen, wcnt, kind, wi, off, lat;
    logic [2:0]  f3;
    logic [31:0] a;
    n_cmp = 0; n_bad = 0; exp_rdata = 32'h0;
    reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_func3 = '0; lat_cfg = 1; stuck = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #3;
    chk("reset_strobes", {28'h0, mem_read, mem_write, cpu_error, cpu_busywait}, 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_mem_bus", {16'h0, 8'h0, mem_address} | mem_wdata, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    reset = 1'b1;
    @(posedge clk); #1;

    preload(8'h04, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 3, 1'b0);
    preload(8'h08, 32'h80001234);
    run_op(1'b1, 1'b0, 32'h23, 3'd0, 32'h0, 1, 1'b0);
    run_op(1'b1, 1'b0, 32'h23, 3'd4, 32'h0, 2, 1'b0);
    run_op(1'b1, 1'b0, 32'h22, 3'd1, 32'h0, 1, 1'b0);
    preload(8'h0A, 32'h11223344);
    run_op(1'b0, 1'b1, 32'h2A, 3'd1, 32'h0000ABCD, 2, 1'b0);
    run_op(1'b1, 1'b0, 32'h11, 3'd2, 32'h0, 1, 1'b0);
    run_op(1'b0, 1'b1, 32'h13, 3'd1, 32'h1234, 1, 1'b0);
    run_op(1'b1, 1'b1, 32'h20, 3'd2, 32'h0, 1, 1'b0);
    run_op(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, 2, 1'b1);

    // Reset while the read half of an SB is in flight.
    preload(8'h30, 32'h55667788);
    lat_cfg = 4; cpu_write = 1'b1; cpu_func3 = 3'd0; cpu_addr = 32'hC1; cpu_wdata = 32'hEE;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_read) begin seen = 1; break; end
    end
    chk("rst_rmw_read_seen", seen, 1);
    #2 reset = 1'b0; cpu_write = 1'b0;
    #1;
    exp_rdata = 32'h0;
    chk("rst_rmw_strobes", {28'h0, mem_read, mem_write, cpu_error, cpu_busywait}, 32'h0);
    chk("rst_rmw_rdata", cpu_rdata, 32'h0);
    chk("rst_rmw_bus", {24'h0, mem_address} | mem_wdata, 32'h0);
    wcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_write) wcnt++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_write) wcnt++;
    end
    chk("rst_rmw_no_write", wcnt, 0);
    chk("rst_rmw_mem", mem[8'h30], ref_mem[8'h30]);
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'hC0, 3'd2, 32'h0, 2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      wi   = int'($urandom_range(0, 255));
      lat  = int'($urandom_range(1, 4));
      if (kind < 5) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd4; 2: f3 = 3'd1; 3: f3 = 3'd5; default: f3 = 3'd2;
        endcase
      end else if (kind < 9) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      off = (kind == 9) ? int'($urandom_range(0, 3)) :
            (f3 == 3'd2) ? 0 : (f3 == 3'd1 || f3 == 3'd5) ? 2 * int'($urandom_range(0, 1)) :
            int'($urandom_range(0, 3));
      a = 32'(wi * 4 + off);
      run_op(kind < 5 || (kind == 9 && $urandom_range(0, 1) == 0), kind >= 5, a, f3,
             $urandom, lat, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
